// File: rtl/conv_pkg.sv
// Shared types for the 5x5 convolution path: pixel and KxK window formats.
// The window generator and the downstream conv stage both import this package.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int K      = 5;

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef pixel_t [K-1:0][K-1:0]    window_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between the pixel source, the window generator
// and the convolution stage.
interface conv_window_gen_if import conv_pkg::*; #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
);

    localparam int ROW_W = cnt_w(IMG_H);
    localparam int COL_W = cnt_w(IMG_W);

    logic             in_valid;
    pixel_t           in_data;
    logic             out_valid;
    window_t          window;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             frame_done;

    // Source side: pushes pixels and observes the emitted windows.
    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  window,
        input  out_row,
        input  out_col,
        input  frame_done
    );

    // Window generator side.
    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output window,
        output out_row,
        output out_col,
        output frame_done
    );

endinterface

// File: rtl/conv_line_buffer.sv
// One image-row delay line: circular RAM with a single pointer and a registered
// tap that presents, at each accept, the pixel written DEPTH accepts earlier.
module conv_line_buffer import conv_pkg::*; #(
    parameter int DEPTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_en,
    input  pixel_t din,
    output pixel_t tap
);

    localparam int                PTR_W    = cnt_w(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    pixel_t           tap_q;

    always_comb begin
        ptr_d = ptr_q;
        if (wr_en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Storage is deliberately not reset; no window uses a row written before
    // the current frame's first K-1 rows.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= din;
        end
    end

    // Read the slot the next accept will overwrite, so the tap already holds
    // the one-row-old pixel when that accept arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            tap_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (wr_en) begin
                tap_q <= mem[ptr_d];
            end
        end
    end

    assign tap = tap_q;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: K-1 chained line buffers feed K
// horizontal shift registers; full windows are registered one cycle after accept.
module conv_window_gen import conv_pkg::*; #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_window_gen_if.slave  bus
);

    localparam int ROW_W = cnt_w(IMG_H);
    localparam int COL_W = cnt_w(IMG_W);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

    logic             accept;
    logic             emit;
    logic             frame_last;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    window_t          sr_q, sr_d;
    window_t          win_q, win_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;

    pixel_t           lb_in  [K-1];
    pixel_t           lb_tap [K-1];
    pixel_t           row_feed [K];

    assign accept     = bus.in_valid;
    assign emit       = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    assign frame_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Line buffer gi delays by gi+1 rows and feeds window row K-2-gi.
    genvar gi;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                assign lb_in[gi] = bus.in_data;
            end else begin : g_chain
                assign lb_in[gi] = lb_tap[gi-1];
            end

            conv_line_buffer #(
                .DEPTH (IMG_W)
            ) u_line_buffer (
                .clk   (clk),
                .rst_n (rst_n),
                .wr_en (accept),
                .din   (lb_in[gi]),
                .tap   (lb_tap[gi])
            );

            assign row_feed[K-2-gi] = lb_tap[gi];
        end
    endgenerate

    assign row_feed[K-1] = bus.in_data;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    sr_d[i][j] = sr_q[i][j+1];
                end
                sr_d[i][K-1] = row_feed[i];
            end
        end
    end

    // The window register captures the post-shift contents so the pixel being
    // accepted lands in [K-1][K-1] on the very next cycle.
    always_comb begin
        win_d        = win_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_valid_d  = emit;
        frame_done_d = emit && frame_last;
        if (emit) begin
            win_d     = sr_d;
            out_row_d = row_q;
            out_col_d = col_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            sr_q         <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            sr_q         <= sr_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.window     = win_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;

endmodule
